// File: rtl/wb_master_engine.sv
// wb_master_engine: queued Wishbone classic master executing write/read/wait-irq commands with one response each
module wb_master_engine #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int CMD_DEPTH   = 4,
    parameter int RSP_DEPTH   = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int IRQ_TIMEOUT = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [1:0]            rsp_op_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    input  logic                  irq_i,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] dat_i
);
    localparam int CAW  = $clog2(CMD_DEPTH);
    localparam int RAW  = $clog2(RSP_DEPTH);
    localparam int CW   = 2 + ADDR_WIDTH + DATA_WIDTH;
    localparam int RW   = 2 + DATA_WIDTH + 1;
    localparam int TMAX = (ACK_TIMEOUT > IRQ_TIMEOUT) ? ACK_TIMEOUT : IRQ_TIMEOUT;
    localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] IRQ_LAST = TW'(IRQ_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, WAIT_IRQ, RESP} state_t;

    state_t                r_state;
    logic [TW-1:0]         r_tmr;
    logic                  r_cmd_vld;
    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_wdat;
    logic [DATA_WIDTH-1:0] r_rdat;
    logic                  r_err;
    logic [CW-1:0]         r_cmd_mem [CMD_DEPTH];
    logic [RW-1:0]         r_rsp_mem [RSP_DEPTH];
    logic [CAW:0]          r_cmd_wr, r_cmd_rd;
    logic [RAW:0]          r_rsp_wr, r_rsp_rd;

    logic          w_cmd_empty, w_cmd_full, w_cmd_push, w_cmd_pop;
    logic          w_rsp_empty, w_rsp_full, w_rsp_push, w_rsp_pop;
    logic          w_ack_to, w_irq_to;
    logic [RW-1:0] w_rsp_head;

    assign w_cmd_empty = r_cmd_wr == r_cmd_rd;
    assign w_cmd_full  = (r_cmd_wr[CAW] != r_cmd_rd[CAW]) && (r_cmd_wr[CAW-1:0] == r_cmd_rd[CAW-1:0]);
    assign w_rsp_empty = r_rsp_wr == r_rsp_rd;
    assign w_rsp_full  = (r_rsp_wr[RAW] != r_rsp_rd[RAW]) && (r_rsp_wr[RAW-1:0] == r_rsp_rd[RAW-1:0]);
    assign w_cmd_push  = cmd_valid_i && !w_cmd_full;
    assign w_cmd_pop   = (r_state == IDLE) && !r_cmd_vld && !w_cmd_empty;
    assign w_rsp_pop   = !w_rsp_empty && rsp_ready_i;
    assign w_rsp_push  = (r_state == RESP) && (!w_rsp_full || rsp_ready_i);
    assign w_ack_to    = (ACK_TIMEOUT != 0) && (r_tmr == ACK_LAST);
    assign w_irq_to    = (IRQ_TIMEOUT != 0) && (r_tmr == IRQ_LAST);
    assign w_rsp_head  = r_rsp_mem[r_rsp_rd[RAW-1:0]];

    assign cmd_ready_o = !w_cmd_full;
    assign rsp_valid_o = !w_rsp_empty;
    assign rsp_op_o    = w_rsp_empty ? '0 : w_rsp_head[RW-1 -: 2];
    assign rsp_dat_o   = w_rsp_empty ? '0 : w_rsp_head[DATA_WIDTH:1];
    assign rsp_err_o   = w_rsp_empty ? 1'b0 : w_rsp_head[0];
    assign busy_o      = (r_state != IDLE) || !w_cmd_empty || r_cmd_vld;

    // FIFO storage; contents are meaningless until the pointers say otherwise
    always_ff @(posedge clk_i) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wr[CAW-1:0]] <= {cmd_op_i, cmd_adr_i, cmd_dat_i};
        if (w_rsp_push) r_rsp_mem[r_rsp_wr[RAW-1:0]] <= {r_op, r_rdat, r_err};
    end

    // FIFO pointers, one bit wider than the index so full/empty are distinguishable
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cmd_wr <= '0;
            r_cmd_rd <= '0;
            r_rsp_wr <= '0;
            r_rsp_rd <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wr <= r_cmd_wr + (CAW+1)'(1);
            if (w_cmd_pop)  r_cmd_rd <= r_cmd_rd + (CAW+1)'(1);
            if (w_rsp_push) r_rsp_wr <= r_rsp_wr + (RAW+1)'(1);
            if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + (RAW+1)'(1);
        end
    end

    // Command engine: pop, dispatch (held off while no response slot is free), bus/irq wait, respond
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_tmr     <= '0;
            r_cmd_vld <= 1'b0;
            r_op      <= '0;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_rdat    <= '0;
            r_err     <= 1'b0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
        end else begin
            r_tmr <= r_tmr + TW'(1);
            case (r_state)
                IDLE: begin
                    if (w_cmd_pop) begin
                        {r_op, r_adr, r_wdat} <= r_cmd_mem[r_cmd_rd[CAW-1:0]];
                        r_cmd_vld <= 1'b1;
                    end else if (r_cmd_vld && !w_rsp_full) begin
                        r_cmd_vld <= 1'b0;
                        r_tmr     <= '0;
                        r_rdat    <= '0;
                        r_err     <= r_op == 2'b11;
                        r_state   <= !r_op[1] ? BUS : (r_op[0] ? RESP : WAIT_IRQ);
                        cyc_o     <= !r_op[1];
                        stb_o     <= !r_op[1];
                        we_o      <= r_op == 2'b00;
                        adr_o     <= !r_op[1] ? r_adr : '0;
                        dat_o     <= (r_op == 2'b00) ? r_wdat : '0;
                    end
                end
                BUS: begin
                    if (ack_i || w_ack_to) begin
                        r_state <= RESP;
                        r_tmr   <= '0;
                        r_err   <= !ack_i;
                        r_rdat  <= (ack_i && r_op[0]) ? dat_i : '0;
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        we_o    <= 1'b0;
                        adr_o   <= '0;
                        dat_o   <= '0;
                    end
                end
                WAIT_IRQ: begin
                    if (irq_i || w_irq_to) begin
                        r_state <= RESP;
                        r_tmr   <= '0;
                        r_err   <= !irq_i;
                    end
                end
                RESP: begin
                    if (w_rsp_push) begin
                        r_state <= IDLE;
                        r_tmr   <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_engine.sv
// tb_wb_master_engine: directed checks of the queued Wishbone master engine
module tb_wb_master_engine;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i = '0;
    logic [1:0] cmd_adr_i = '0;
    logic [7:0] cmd_dat_i = '0;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b0;
    logic [1:0] rsp_op_o;
    logic [7:0] rsp_dat_o;
    logic       rsp_err_o;
    logic       busy_o;
    logic       irq_i = 1'b0;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic       ack_i = 1'b0;
    logic [7:0] dat_i = '0;
    int         tests = 0;
    int         fails = 0;
    int         n;

    wb_master_engine #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .CMD_DEPTH(4), .RSP_DEPTH(4),
        .ACK_TIMEOUT(8), .IRQ_TIMEOUT(64)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_op_o(rsp_op_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .irq_i(irq_i),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [1:0] adr, input logic [7:0] dat);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic pop();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic wait_cyc();
        for (int i = 0; i < 20 && !cyc_o; i++) tick();
        check("wait_cyc", cyc_o, 1);
    endtask

    // counts cycles with cyc_o high; acks in cycle ack_at (0 = never)
    task automatic bus_count(input int ack_at, input logic [7:0] rd, output int cnt);
        cnt = 0;
        while (cyc_o && cnt < 50) begin
            cnt++;
            ack_i = (cnt == ack_at);
            dat_i = (cnt == ack_at) ? rd : 8'h00;
            tick();
        end
        ack_i = 1'b0;
        dat_i = 8'h00;
    endtask

    initial begin
        tick();
        tick();
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_we", we_o, 0);
        check("rst_adr", adr_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_fields", {rsp_op_o, rsp_dat_o, rsp_err_o}, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 1);
        rst_i = 1'b1;
        tick();

        push(2'b00, 2'd2, 8'hA5);
        check("busy_queued", busy_o, 1);
        tick();
        check("lat_not_yet", cyc_o, 0);
        tick();
        check("wr_cyc", cyc_o, 1);
        check("wr_stb", stb_o, 1);
        check("wr_we", we_o, 1);
        check("wr_adr", adr_o, 2);
        check("wr_dat", dat_o, 8'hA5);
        bus_count(3, 8'h00, n);
        check("wr_cyc_len", n, 3);
        check("wr_idle_bus", {we_o, adr_o, dat_o}, 0);
        check("wr_rsp_early", rsp_valid_o, 0);
        tick();
        check("wr_rsp_valid", rsp_valid_o, 1);
        check("wr_rsp", {rsp_op_o, rsp_dat_o, rsp_err_o}, {2'b00, 8'h00, 1'b0});
        check("wr_busy_done", busy_o, 0);
        pop();
        check("wr_rsp_popped", rsp_valid_o, 0);

        push(2'b01, 2'd1, 8'hFF);
        wait_cyc();
        check("rd_we", we_o, 0);
        check("rd_adr", adr_o, 1);
        check("rd_dat_o", dat_o, 0);
        bus_count(1, 8'h3C, n);
        check("rd_cyc_len", n, 1);
        tick();
        check("rd_rsp", {rsp_valid_o, rsp_op_o, rsp_dat_o, rsp_err_o}, {1'b1, 2'b01, 8'h3C, 1'b0});
        pop();

        push(2'b01, 2'd3, 8'h00);
        push(2'b00, 2'd1, 8'h5A);
        wait_cyc();
        bus_count(0, 8'h00, n);
        check("to_cyc_len", n, 8);
        tick();
        check("to_rsp", {rsp_valid_o, rsp_op_o, rsp_dat_o, rsp_err_o}, {1'b1, 2'b01, 8'h00, 1'b1});
        pop();
        wait_cyc();
        check("to_next_bus", {we_o, adr_o, dat_o}, {1'b1, 2'd1, 8'h5A});
        bus_count(2, 8'h00, n);
        check("to_next_len", n, 2);
        tick();
        check("to_next_rsp", {rsp_valid_o, rsp_op_o, rsp_err_o}, {1'b1, 2'b00, 1'b0});
        pop();

        for (int k = 0; k < 4; k++) begin
            push(2'b01, 2'(k), 8'h00);
            wait_cyc();
            bus_count(1, 8'h10 + 8'(k), n);
        end
        push(2'b01, 2'd0, 8'h00);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n += int'(cyc_o);
        end
        check("bp_no_bus", n, 0);
        check("bp_head", {rsp_valid_o, rsp_dat_o}, {1'b1, 8'h10});
        check("bp_busy", busy_o, 1);
        pop();
        wait_cyc();
        bus_count(1, 8'h14, n);
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("bp_order", {rsp_valid_o, rsp_dat_o}, {1'b1, 8'h10 + 8'(k)});
            pop();
        end
        check("bp_drained", rsp_valid_o, 0);

        push(2'b10, 2'd0, 8'h00);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            n += int'(cyc_o) + int'(rsp_valid_o);
            tick();
        end
        check("irq_quiet", n, 0);
        irq_i = 1'b1;
        tick();
        check("irq_resp_cycle", rsp_valid_o, 0);
        tick();
        check("irq_rsp", {rsp_valid_o, rsp_op_o, rsp_dat_o, rsp_err_o}, {1'b1, 2'b10, 8'h00, 1'b0});
        pop();
        push(2'b10, 2'd0, 8'h00);
        tick();
        tick();
        tick();
        check("irq_pre_rsp", rsp_valid_o, 0);
        tick();
        check("irq_entry_rsp", {rsp_valid_o, rsp_op_o, rsp_err_o}, {1'b1, 2'b10, 1'b0});
        pop();
        irq_i = 1'b0;

        push(2'b11, 2'd1, 8'hFF);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            n += int'(cyc_o);
            tick();
        end
        check("rsv_no_bus", n, 0);
        check("rsv_rsp", {rsp_valid_o, rsp_op_o, rsp_dat_o, rsp_err_o}, {1'b1, 2'b11, 8'h00, 1'b1});
        pop();

        push(2'b01, 2'd2, 8'h00);
        wait_cyc();
        push(2'b00, 2'd1, 8'h11);
        push(2'b00, 2'd3, 8'h22);
        check("rst_mid_cyc", cyc_o, 1);
        rst_i = 1'b0;
        #1;
        check("rst_async_cyc", {cyc_o, stb_o}, 0);
        tick();
        rst_i = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(cyc_o) + int'(rsp_valid_o) + int'(busy_o);
        end
        check("rst_discarded", n, 0);
        check("rst_after_state", {rsp_valid_o, busy_o, cmd_ready_o}, {1'b0, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
